display_scheduler: RTL and testbench
====================================

# display_scheduler

Display scheduler for the power estimator's 7-segment readout. It accepts NUM_CH signed Q5.22 measurement channels, such as current, voltage and power. Each channel is block-averaged over 2^AVG_LOG2 samples. At a fixed refresh rate, one channel's held average is presented to the downstream segment decoder. The displayed channel is chosen by a debounced pushbutton, or rotates automatically.

## Interface
Parameters:
- NUM_CH, 3, number of measurement channels (2..8)
- AVG_LOG2, 4, log2 of the samples averaged per channel
- REFRESH_CYCLES, 12_500_000, clk cycles between display refreshes (0.25 s at 50 MHz)
- DEBOUNCE_CYCLES, 500_000, cycles the key must be stable before a press or release is accepted
- AUTO_DWELL, 8, refreshes per channel in auto mode

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high
- sample_in  in  NUM_CH*27  packed signed Q5.22 samples; channel i occupies bits [27i+26:27i]
- sample_valid  in  NUM_CH  per-channel strobe, one sample per high cycle
- key_n  in  1  raw pushbutton, active-low, asynchronous
- auto_mode  in  1  level; 1 = rotate channels automatically
- disp_value  out  27  signed Q5.22 value for the segment decoder
- disp_ch  out  $clog2(NUM_CH)  index of the displayed channel
- disp_valid  out  1  the displayed channel has completed at least one average
- disp_update  out  1  one-cycle pulse when disp_value/disp_ch change

## Operation
- Averaging, per channel:
  - Accumulator is signed, 27+AVG_LOG2 bits wide, so it cannot overflow.
  - Sample counter is AVG_LOG2 bits wide.
  - On a valid with count < 2^AVG_LOG2-1: acc += sample, count++.
  - On a valid with count == 2^AVG_LOG2-1: hold <= (acc+sample) >>> AVG_LOG2 (arithmetic shift, truncation toward -inf); acc <= 0; count <= 0; avail <= 1.
  - Channels run independently; simultaneous valids on all channels are all accepted.
- Key path:
  - 2-flop synchronizer feeds the key_debounce FSM.
  - States: IDLE → PRESS_WAIT (key low) → PRESSED (held low DEBOUNCE_CYCLES) → RELEASE_WAIT (key high) → IDLE (held high DEBOUNCE_CYCLES).
  - A bounce back to the prior level in either WAIT state returns to the prior stable state and reloads the counter.
  - Entering PRESSED emits a one-cycle press pulse.
- Selection:
  - sel advances on a press pulse or, in auto mode, after AUTO_DWELL timer-driven refreshes. It wraps from NUM_CH-1 to 0.
  - If a press and an auto advance occur in the same cycle, sel advances once only.
  - A press also clears the dwell counter.
- Refresh:
  - The refresh timer counts down from REFRESH_CYCLES-1.
  - A refresh event is timer==0 or a sel change. A sel change also reloads the timer.
  - On the event: disp_value <= hold[sel_new], disp_ch <= sel_new, disp_valid <= avail[sel_new].
  - If the hold register is being written in the same cycle as the refresh, the old hold value is displayed.
- Toggling auto_mode does not by itself cause an update. Clearing auto_mode clears the dwell counter.

## Timing
- Reset state:
  - Outputs: disp_value=0, disp_ch=0, disp_valid=0, disp_update=0.
  - Internal: sel=0, all acc/count/hold/avail=0, timer=REFRESH_CYCLES-1, dwell=0, debouncer IDLE.
- Reset asserted mid-average or mid-debounce discards all partial state immediately.
- Refresh event in cycle t → new outputs registered at t+1, with disp_update=1 in t+1 only.
- Outputs are otherwise stable between updates.
- Key-to-display latency is 2 (synchronizer) + DEBOUNCE_CYCLES + 1 (press pulse) + 1 (output register) cycles from the first stable low sample.
- A sample-to-hold update takes effect on the cycle after the final valid.

## Structure
- Shared package power_disp_pkg holds:
  - SAMPLE_W=27 and FRAC_W=22.
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
  - The debounce state enum.
- Sub-module key_debounce (synchronizer, FSM, counter; press pulse out) is instantiated once.
- Averaging uses a generate loop over channels inside display_scheduler.

## Test plan
Bench parameters: NUM_CH=3, AVG_LOG2=2, REFRESH_CYCLES=16, DEBOUNCE_CYCLES=4.
- Average: ch0 samples 0x0400000, 0x0400000, 0x0800000, 0x0800000 (1,1,2,2) → next refresh: disp_value=0x0600000 (1.5), disp_valid=1, disp_ch=0.
- Negative rounding: ch0 samples -1,-1,-1,0 raw LSB → hold=-1 (arithmetic shift). An all-zero block gives 0.
- Bounce: key_n low 2 cycles, high 1, low 6 → exactly one advance, disp_ch=1, one disp_update pulse, timer reloaded.
- Auto mode: auto_mode=1, no key → disp_ch sequence 0,1,2,0 every 8 refreshes (128 cycles). A press coincident with the dwell advance moves sel by one only.
- Boundaries:
  - Hold write coinciding with a refresh shows the old hold value; the next refresh shows the new one.
  - reset pulsed mid-block (after 2 samples) → the following 4 samples alone form the average; all outputs read 0 during and immediately after reset.

Source files
------------

// File: rtl/power_disp_pkg.sv
// ============================================================================
//  Module      : power_disp_pkg
//  Description : Shared types and constants for the power-estimator display
//                path: Q5.22 sample format and the key debouncer state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package power_disp_pkg;

    // Signed fixed-point Q5.22 measurement sample
    localparam int SAMPLE_W = 27;
    localparam int FRAC_W   = 22;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Debouncer states: two stable levels, each with a qualifying wait state
    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer plus debounce FSM for an active-low
//                pushbutton. Emits a one-cycle press pulse on entering the
//                stable-pressed state.
//  Ports       : clk   - system clock
//                reset - asynchronous active-high reset
//                key_n - raw pushbutton, active-low, asynchronous
//                press - one-cycle pulse per accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
    import power_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int              c_cnt_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    db_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;

    // Synchronizer resets to the released level so reset never fakes a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= DB_IDLE;
            r_cnt   <= c_reload;
            press   <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            press   <= 1'b0;
            case (r_state)
                DB_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= DB_PRESS_WAIT;
                        r_cnt   <= c_reload;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (r_sync2) begin
                        r_state <= DB_IDLE;          // bounced back high
                    end else if (r_cnt == '0) begin
                        r_state <= DB_PRESSED;
                        press   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DB_PRESSED: begin
                    if (r_sync2) begin
                        r_state <= DB_RELEASE_WAIT;
                        r_cnt   <= c_reload;
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= DB_PRESSED;       // bounced back low, no new pulse
                    end else if (r_cnt == '0) begin
                        r_state <= DB_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= DB_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scheduler.sv
// ============================================================================
//  Module      : display_scheduler
//  Description : Block-averages NUM_CH signed Q5.22 channels and presents one
//                channel's held average to the 7-segment decoder at a fixed
//                refresh rate. Channel selected by debounced key or auto
//                rotation.
//  Ports       : clk          - system clock
//                reset        - asynchronous active-high reset
//                sample_in    - packed samples, channel i at [27i+26:27i]
//                sample_valid - per-channel sample strobe
//                key_n        - raw active-low pushbutton
//                auto_mode    - 1 = rotate channels automatically
//                disp_value   - displayed average (Q5.22)
//                disp_ch      - displayed channel index
//                disp_valid   - displayed channel has a completed average
//                disp_update  - one-cycle pulse when outputs change
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scheduler
    import power_disp_pkg::*;
#(
    parameter int NUM_CH          = 3,
    parameter int AVG_LOG2        = 4,
    parameter int REFRESH_CYCLES  = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int AUTO_DWELL      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH*SAMPLE_W-1:0]  sample_in,
    input  logic [NUM_CH-1:0]           sample_valid,
    input  logic                        key_n,
    input  logic                        auto_mode,
    output sample_t                     disp_value,
    output logic [$clog2(NUM_CH)-1:0]   disp_ch,
    output logic                        disp_valid,
    output logic                        disp_update
);

    localparam int c_sel_w   = $clog2(NUM_CH);
    localparam int c_acc_w   = SAMPLE_W + AVG_LOG2;
    localparam int c_tmr_w   = $clog2(REFRESH_CYCLES);
    localparam int c_dwell_w = $clog2(AUTO_DWELL + 1);

    localparam logic [c_sel_w-1:0]   c_sel_last   = c_sel_w'(NUM_CH - 1);
    localparam logic [c_tmr_w-1:0]   c_tmr_reload = c_tmr_w'(REFRESH_CYCLES - 1);
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(AUTO_DWELL - 1);

    // ------------------------------------------------------------------
    // Per-channel block averaging
    // ------------------------------------------------------------------
    sample_t           w_hold [NUM_CH];
    logic [NUM_CH-1:0] w_avail;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_avg
        logic signed [c_acc_w-1:0] r_acc;
        logic [AVG_LOG2-1:0]       r_cnt;
        sample_t                   r_hold;
        logic                      r_avail;
        sample_t                   w_smp;
        logic signed [c_acc_w-1:0] w_sum;

        assign w_smp = sample_in[g*SAMPLE_W +: SAMPLE_W];
        assign w_sum = r_acc + {{AVG_LOG2{w_smp[SAMPLE_W-1]}}, w_smp};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_hold  <= '0;
                r_avail <= 1'b0;
            end else if (sample_valid[g]) begin
                if (r_cnt == '1) begin
                    // Upper bits of the sum are the arithmetic shift (floor divide)
                    r_hold  <= w_sum[AVG_LOG2 +: SAMPLE_W];
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_avail <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_hold[g]  = r_hold;
        assign w_avail[g] = r_avail;
    end

    // ------------------------------------------------------------------
    // Key path
    // ------------------------------------------------------------------
    logic w_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .press (w_press)
    );

    // ------------------------------------------------------------------
    // Selection and refresh
    // ------------------------------------------------------------------
    logic [c_sel_w-1:0]   r_sel;
    logic [c_tmr_w-1:0]   r_timer;
    logic [c_dwell_w-1:0] r_dwell;

    logic               w_tick;
    logic               w_dwell_done;
    logic               w_auto_adv;
    logic               w_adv;
    logic               w_refresh;
    logic [c_sel_w-1:0] w_sel_next;

    assign w_tick       = (r_timer == '0);
    assign w_dwell_done = (r_dwell == c_dwell_last);
    assign w_auto_adv   = auto_mode && w_tick && w_dwell_done;
    // A press and an auto advance in the same cycle merge into one step.
    assign w_adv        = w_press || w_auto_adv;
    assign w_sel_next   = !w_adv               ? r_sel :
                          (r_sel == c_sel_last) ? '0    : r_sel + 1'b1;
    assign w_refresh    = w_tick || w_adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel       <= '0;
            r_timer     <= c_tmr_reload;
            r_dwell     <= '0;
            disp_value  <= '0;
            disp_ch     <= '0;
            disp_valid  <= 1'b0;
            disp_update <= 1'b0;
        end else begin
            r_sel       <= w_sel_next;
            r_timer     <= w_refresh ? c_tmr_reload : r_timer - 1'b1;
            disp_update <= w_refresh;

            if (!auto_mode || w_press) begin
                r_dwell <= '0;
            end else if (w_tick) begin
                r_dwell <= w_dwell_done ? '0 : r_dwell + 1'b1;
            end

            // Hold registers update on this same edge, so a coincident
            // block completion shows the previous average here.
            if (w_refresh) begin
                disp_value <= w_hold[w_sel_next];
                disp_ch    <= w_sel_next;
                disp_valid <= w_avail[w_sel_next];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scheduler.sv
// ============================================================================
//  Module      : tb_display_scheduler
//  Description : Directed self-checking bench for display_scheduler with
//                NUM_CH=3, AVG_LOG2=2, REFRESH_CYCLES=16, DEBOUNCE_CYCLES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scheduler;

    logic          clk = 1'b0;
    logic          reset;
    logic [80:0]   sample_in;
    logic [2:0]    sample_valid;
    logic          key_n;
    logic          auto_mode;
    logic [26:0]   disp_value;
    logic [1:0]    disp_ch;
    logic          disp_valid;
    logic          disp_update;

    int n_cmp = 0;
    int n_bad = 0;

    display_scheduler #(
        .NUM_CH          (3),
        .AVG_LOG2        (2),
        .REFRESH_CYCLES  (16),
        .DEBOUNCE_CYCLES (4),
        .AUTO_DWELL      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .key_n        (key_n),
        .auto_mode    (auto_mode),
        .disp_value   (disp_value),
        .disp_ch      (disp_ch),
        .disp_valid   (disp_valid),
        .disp_update  (disp_update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample on each channel selected by m, for one cycle
    task automatic send(input logic [26:0] v0, input logic [26:0] v1,
                        input logic [26:0] v2, input logic [2:0] m);
        sample_in    = {v2, v1, v0};
        sample_valid = m;
        @(negedge clk);
        sample_valid = 3'b000;
    endtask

    task automatic wait_upd(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (disp_update) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_value"},  {5'd0, disp_value},   32'd0);
        chk({tag, "_ch"},     {30'd0, disp_ch},     32'd0);
        chk({tag, "_valid"},  {31'd0, disp_valid},  32'd0);
        chk({tag, "_update"}, {31'd0, disp_update}, 32'd0);
    endtask

    initial begin : main
        int nupd;
        int first_idx;
        int second_idx;
        int cyc;
        logic [1:0]  prev_ch;
        logic [1:0]  first_ch;
        logic [26:0] first_val;
        logic [1:0]  exp_ch  [3];
        logic [26:0] exp_val [3];

        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 3'b000;
        key_n        = 1'b1;
        auto_mode    = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        // ---- average of 1,1,2,2 -> 1.5 ----
        send(27'h0400000, 27'd0, 27'd0, 3'b001);
        send(27'h0400000, 27'd0, 27'd0, 3'b001);
        send(27'h0800000, 27'd0, 27'd0, 3'b001);
        send(27'h0800000, 27'd0, 27'd0, 3'b001);
        wait_upd("avg_upd_seen", 40);
        chk("avg_value", {5'd0, disp_value}, 32'h0600000);
        chk("avg_valid", {31'd0, disp_valid}, 32'd1);
        chk("avg_ch",    {30'd0, disp_ch},    32'd0);
        @(negedge clk);
        chk("avg_update_one_cycle", {31'd0, disp_update}, 32'd0);

        // ---- negative rounding: -1,-1,-1,0 -> -1 ----
        send(27'h7FFFFFF, 27'd0, 27'd0, 3'b001);
        send(27'h7FFFFFF, 27'd0, 27'd0, 3'b001);
        send(27'h7FFFFFF, 27'd0, 27'd0, 3'b001);
        send(27'h0000000, 27'd0, 27'd0, 3'b001);
        wait_upd("neg_upd_seen", 40);
        chk("neg_value", {5'd0, disp_value}, 32'h07FFFFFF);

        // ---- all-zero block on ch0, simultaneous blocks on ch1/ch2 ----
        send(27'd0, 27'h0C00000, 27'd5, 3'b111);
        send(27'd0, 27'h0C00000, 27'd6, 3'b111);
        send(27'd0, 27'h0C00000, 27'd7, 3'b111);
        send(27'd0, 27'h0C00000, 27'd9, 3'b111);
        wait_upd("zero_upd_seen", 40);
        chk("zero_value", {5'd0, disp_value}, 32'd0);
        chk("zero_valid", {31'd0, disp_valid}, 32'd1);

        // ---- hold write coinciding with a refresh (tick 16 cycles later) ----
        send(27'h0200000, 27'd0, 27'd0, 3'b001);
        send(27'h0200000, 27'd0, 27'd0, 3'b001);
        send(27'h0200000, 27'd0, 27'd0, 3'b001);
        repeat (12) @(negedge clk);
        send(27'h0200000, 27'd0, 27'd0, 3'b001);
        chk("coin_update", {31'd0, disp_update}, 32'd1);
        chk("coin_old_value", {5'd0, disp_value}, 32'd0);
        wait_upd("coin_next_upd_seen", 40);
        chk("coin_new_value", {5'd0, disp_value}, 32'h0200000);

        // ---- bouncy key: low 2, high 1, low 6 ----
        nupd = 0; first_idx = -1; second_idx = -1;
        first_ch = '0; first_val = '0;
        for (int k = 0; k < 30; k++) begin
            key_n = (k == 0 || k == 1 || (k >= 3 && k <= 8)) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (disp_update) begin
                nupd++;
                if (first_idx < 0) begin
                    first_idx = k + 1;
                    first_ch  = disp_ch;
                    first_val = disp_value;
                end else if (second_idx < 0) begin
                    second_idx = k + 1;
                end
            end
        end
        chk("key_update_count", nupd, 32'd2);
        chk("key_update_cycle", first_idx, 32'd11);
        chk("key_ch", {30'd0, first_ch}, 32'd1);
        chk("key_value", {5'd0, first_val}, 32'h0C00000);
        chk("key_timer_reload", second_idx, 32'd27);

        // ---- auto rotation from ch1: 2, 0, 1 every 8 refreshes ----
        wait_upd("auto_align_seen", 40);
        auto_mode  = 1'b1;
        exp_ch[0]  = 2'd2; exp_val[0] = 27'd6;
        exp_ch[1]  = 2'd0; exp_val[1] = 27'h0200000;
        exp_ch[2]  = 2'd1; exp_val[2] = 27'h0C00000;
        for (int r = 0; r < 3; r++) begin
            prev_ch = disp_ch;
            cyc = 0; nupd = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (disp_update) nupd++;
            end while (disp_ch == prev_ch && cyc < 400);
            chk($sformatf("auto%0d_cycles", r), cyc, 32'd128);
            chk($sformatf("auto%0d_refreshes", r), nupd, 32'd8);
            chk($sformatf("auto%0d_ch", r), {30'd0, disp_ch}, {30'd0, exp_ch[r]});
            chk($sformatf("auto%0d_value", r), {5'd0, disp_value}, {5'd0, exp_val[r]});
        end

        // ---- press coincident with the dwell advance: one step only ----
        nupd = 0;
        for (int k = 0; k < 128; k++) begin
            key_n = (k >= 120 && k <= 125) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (disp_update) nupd++;
        end
        key_n = 1'b1;
        chk("coinc_press_update", {31'd0, disp_update}, 32'd1);
        chk("coinc_press_ch", {30'd0, disp_ch}, 32'd2);
        chk("coinc_press_refreshes", nupd, 32'd8);
        auto_mode = 1'b0;

        // ---- reset mid-block discards the partial sum ----
        send(27'h1000000, 27'd0, 27'd0, 3'b001);
        send(27'h1000000, 27'd0, 27'd0, 3'b001);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk_zero("postrst");
        send(27'h0400000, 27'd0, 27'd0, 3'b001);
        send(27'h0400000, 27'd0, 27'd0, 3'b001);
        send(27'h0400000, 27'd0, 27'd0, 3'b001);
        send(27'h0400000, 27'd0, 27'd0, 3'b001);
        wait_upd("rst_avg_upd_seen", 40);
        chk("rst_avg_value", {5'd0, disp_value}, 32'h0400000);
        chk("rst_avg_ch",    {30'd0, disp_ch},   32'd0);
        chk("rst_avg_valid", {31'd0, disp_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
